// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   - Default parameter values and the widths derived from them.
//   - onehot_to_idx: encodes a one-hot grant vector as a binary index.
//     Both the write and the read arbiter use it.
package mem_arb_pkg;

  localparam int unsigned DEF_BIT_LENGTH = 64;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_NUM_WR     = 4;
  localparam int unsigned DEF_NUM_RD     = 4;

  localparam int unsigned AW = $clog2(DEF_DEPTH);
  localparam int unsigned IW = $clog2(DEF_NUM_RD);
  localparam int unsigned WW = $clog2(DEF_NUM_WR);

  // Widest requester vector that onehot_to_idx accepts. Callers
  // zero-extend their grant vectors to this width.
  localparam int unsigned MAX_REQ = 256;

  // The input is one-hot, so OR-ing the bit positions gives the index.
  // No priority chain is needed.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock and synchronous active-low reset
//   req        : per-requester request
//   gnt        : one-hot grant (combinational); forced to 0 while rst_n is low
//   gnt_idx    : binary index of the granted requester
//   gnt_valid  : a grant was issued this cycle
// The pointer moves to one past the winner. As a result, a requester that
// holds its request is served within N cycles.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] ptr;
  logic [2*N-1:0]   req_dbl;
  logic [2*N-1:0]   gnt_dbl;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     pick_rot;

  // Rotate the requests so that the pointer position becomes bit 0.
  // Take the lowest set bit, then rotate the result back.
  always_comb begin
    req_dbl  = {req, req} >> ptr;
    req_rot  = req_dbl[N-1:0];
    pick_rot = req_rot & ((~req_rot) + N'(1));
    gnt_dbl  = {{N{1'b0}}, pick_rot} << ptr;
    gnt      = '0;
    if (rst_n) gnt = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
  end

  assign gnt_valid = |gnt;
  assign gnt_idx   = IDX_W'(onehot_to_idx(MAX_REQ'(gnt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one read-first two-port memory between multiple requesters.
//   Port A (write): NUM_WR requesters, round-robin arbitrated.
//   Port B (read) : NUM_RD requesters, round-robin arbitrated.
//   wr_req/wr_addr/wr_data -> wr_gnt  : write request side
//   rd_req/rd_addr         -> rd_gnt  : read request side
//   rd_valid/rd_id/rd_data            : read return, one cycle after grant
//   mem_ena/mem_wea/mem_addra/mem_dina : memory port A
//   mem_enb/mem_addrb/mem_doutb        : memory port B
// Grants are forwarded to the memory in the same cycle they are issued.
// Nothing is latched from the requesters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned BIT_LENGTH = DEF_BIT_LENGTH,
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned NUM_WR     = DEF_NUM_WR,
  parameter  int unsigned NUM_RD     = DEF_NUM_RD,
  localparam int unsigned ADDR_W     = $clog2(DEPTH),
  localparam int unsigned ID_W       = $clog2(NUM_RD),
  localparam int unsigned WR_W       = $clog2(NUM_WR)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WR-1:0]              wr_req,
  input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
  input  logic [NUM_WR*BIT_LENGTH-1:0]   wr_data,
  output logic [NUM_WR-1:0]              wr_gnt,
  input  logic [NUM_RD-1:0]              rd_req,
  input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
  output logic [NUM_RD-1:0]              rd_gnt,
  output logic                           rd_valid,
  output logic [ID_W-1:0]                rd_id,
  output logic [BIT_LENGTH-1:0]          rd_data,
  output logic                           mem_ena,
  output logic                           mem_wea,
  output logic [ADDR_W-1:0]              mem_addra,
  output logic [BIT_LENGTH-1:0]          mem_dina,
  output logic                           mem_enb,
  output logic [ADDR_W-1:0]              mem_addrb,
  input  logic [BIT_LENGTH-1:0]          mem_doutb
);

  logic [WR_W-1:0] wr_idx;
  logic            wr_any;
  logic [ID_W-1:0] rd_idx;
  logic            rd_any;

  // Unpacked views of the packed request buses, indexed by grant index.
  logic [ADDR_W-1:0]     wr_addr_a [NUM_WR];
  logic [BIT_LENGTH-1:0] wr_data_a [NUM_WR];
  logic [ADDR_W-1:0]     rd_addr_a [NUM_RD];

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_view
    assign wr_addr_a[i] = wr_addr[i*ADDR_W +: ADDR_W];
    assign wr_data_a[i] = wr_data[i*BIT_LENGTH +: BIT_LENGTH];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_view
    assign rd_addr_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
  end

  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (wr_req),
    .gnt       (wr_gnt),
    .gnt_idx   (wr_idx),
    .gnt_valid (wr_any)
  );

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (rd_req),
    .gnt       (rd_gnt),
    .gnt_idx   (rd_idx),
    .gnt_valid (rd_any)
  );

  // Address and data are zeroed when idle so the memory sees a quiet bus.
  always_comb begin
    mem_ena   = wr_any;
    mem_wea   = wr_any;
    mem_addra = '0;
    mem_dina  = '0;
    if (wr_any) begin
      mem_addra = wr_addr_a[wr_idx];
      mem_dina  = wr_data_a[wr_idx];
    end
  end

  always_comb begin
    mem_enb   = rd_any;
    mem_addrb = '0;
    if (rd_any) mem_addrb = rd_addr_a[rd_idx];
  end

  // The memory registers the read internally, so only the tag needs
  // tracking here. The data is a passthrough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      rd_valid <= rd_any;
      if (rd_any) rd_id <= rd_idx;
    end
  end

  assign rd_data = mem_doutb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int BL    = 64;
  localparam int DEPTH = 16;
  localparam int NW    = 4;
  localparam int NR    = 4;
  localparam int AW    = 4;
  localparam int IW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NW-1:0]    wr_req;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*BL-1:0] wr_data;
  logic [NW-1:0]    wr_gnt;
  logic [NR-1:0]    rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_gnt;
  logic             rd_valid;
  logic [IW-1:0]    rd_id;
  logic [BL-1:0]    rd_data;
  logic             mem_ena, mem_wea, mem_enb;
  logic [AW-1:0]    mem_addra, mem_addrb;
  logic [BL-1:0]    mem_dina, mem_doutb;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .BIT_LENGTH (BL),
    .DEPTH      (DEPTH),
    .NUM_WR     (NW),
    .NUM_RD     (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_id     (rd_id),
    .rd_data   (rd_data),
    .mem_ena   (mem_ena),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_enb   (mem_enb),
    .mem_addrb (mem_addrb),
    .mem_doutb (mem_doutb)
  );

  always #5 clk = ~clk;

  // Read-first two-port memory driven by the DUT's memory pins.
  logic [BL-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_enb) mem_doutb <= env_mem[mem_addrb];
    if (mem_ena && mem_wea) env_mem[mem_addra] <= mem_dina;
  end

  // ---------------- reference model ----------------
  int            m_wr_ptr, m_rd_ptr;
  bit            m_rd_valid;
  int            m_rd_id;
  logic [BL-1:0] m_rd_data;
  bit            m_rd_known;
  logic [BL-1:0] ref_mem [DEPTH];
  bit            ref_known [DEPTH];
  int            e_wi, e_ri;
  logic [NW-1:0] e_wr_gnt;
  logic [NR-1:0] e_rd_gnt;
  logic [AW-1:0] e_addra, e_addrb;
  logic [BL-1:0] e_dina;

  function automatic int rr_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (ptr + k) % 4;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_eval();
    e_wi     = rst_n ? rr_pick(wr_req, m_wr_ptr) : -1;
    e_ri     = rst_n ? rr_pick(rd_req, m_rd_ptr) : -1;
    e_wr_gnt = (e_wi >= 0) ? NW'(1 << e_wi) : '0;
    e_rd_gnt = (e_ri >= 0) ? NR'(1 << e_ri) : '0;
    e_addra  = (e_wi >= 0) ? wr_addr[e_wi*AW +: AW] : '0;
    e_dina   = (e_wi >= 0) ? wr_data[e_wi*BL +: BL] : '0;
    e_addrb  = (e_ri >= 0) ? rd_addr[e_ri*AW +: AW] : '0;
  endtask

  task automatic model_clock();
    if (!rst_n) begin
      m_wr_ptr   = 0;
      m_rd_ptr   = 0;
      m_rd_valid = 0;
      m_rd_id    = 0;
    end else begin
      if (e_wi >= 0) m_wr_ptr = (e_wi + 1) % NW;
      if (e_ri >= 0) m_rd_ptr = (e_ri + 1) % NR;
      m_rd_valid = (e_ri >= 0);
      if (e_ri >= 0) begin
        m_rd_id    = e_ri;
        m_rd_data  = ref_mem[e_addrb];
        m_rd_known = ref_known[e_addrb];
      end
      if (e_wi >= 0) begin
        ref_mem[e_addra]   = e_dina;
        ref_known[e_addra] = 1;
      end
    end
  endtask

  // settle: move to the sampling point and compute expectations.
  // advance: cross the active edge and update the model.
  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    wr_req  = '0;
    rd_req  = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    settle();
    advance();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n   = 1'b0;
    wr_req  = '1;
    rd_req  = '1;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_vec++;
      if (wr_gnt !== 4'b0000 || rd_gnt !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_gnt cyc %0d got wr %b rd %b exp 0000 0000", c, wr_gnt, rd_gnt);
      end
      n_vec++;
      if (mem_ena !== 1'b0 || mem_wea !== 1'b0 || mem_enb !== 1'b0) begin
        n_err++;
        $display("FAIL reset_en cyc %0d got ena %b wea %b enb %b exp 0 0 0", c, mem_ena, mem_wea, mem_enb);
      end
      if (c > 0) begin
        n_vec++;
        if (rd_valid !== 1'b0 || rd_id !== 2'd0) begin
          n_err++;
          $display("FAIL reset_rd cyc %0d got valid %b id %0d exp 0 0", c, rd_valid, rd_id);
        end
      end
      advance();
    end
    rst_n  = 1'b1;
    rd_req = '0;
    settle();
    n_vec++;
    if (wr_gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_gnt got %b exp 0001", wr_gnt);
    end
    advance();
  endtask

  task automatic test_round_robin();
    do_reset();
    wr_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wr_addr = NW*AW'($urandom);
      wr_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      settle();
      n_vec++;
      if (wr_gnt !== NW'(1 << (k % 4))) begin
        n_err++;
        $display("FAIL rr_gnt cyc %0d got %b exp %b", k, wr_gnt, NW'(1 << (k % 4)));
      end
      n_vec++;
      if (mem_addra !== wr_addr[(k%4)*AW +: AW] || mem_dina !== wr_data[(k%4)*BL +: BL]) begin
        n_err++;
        $display("FAIL rr_slice cyc %0d got addr %0d data %h exp addr %0d data %h",
                 k, mem_addra, mem_dina, wr_addr[(k%4)*AW +: AW], wr_data[(k%4)*BL +: BL]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_pointer_skip();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    do_reset();
    wr_req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_vec++;
      if (wr_gnt !== exp_seq[k] || mem_ena !== 1'b1 || mem_wea !== 1'b1) begin
        n_err++;
        $display("FAIL skip_gnt cyc %0d got %b ena %b wea %b exp %b 1 1", k, wr_gnt, mem_ena, mem_wea, exp_seq[k]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_read_tag();
    do_reset();
    wr_req = 4'b0001;
    wr_addr[0 +: AW] = 4'd5;
    wr_data[0 +: BL] = 64'hDEAD_BEEF;
    settle();
    advance();
    idle_inputs();
    rd_req = 4'b0100;
    rd_addr[2*AW +: AW] = 4'd5;
    settle();
    n_vec++;
    if (rd_gnt !== 4'b0100 || mem_enb !== 1'b1 || mem_addrb !== 4'd5) begin
      n_err++;
      $display("FAIL tag_gnt got gnt %b enb %b addr %0d exp 0100 1 5", rd_gnt, mem_enb, mem_addrb);
    end
    advance();
    idle_inputs();
    settle();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_id !== 2'd2 || rd_data !== 64'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL tag_return got valid %b id %0d data %h exp 1 2 deadbeef", rd_valid, rd_id, rd_data);
    end
    advance();
  endtask

  task automatic test_collision();
    do_reset();
    wr_req = 4'b0001;
    wr_addr[0 +: AW] = 4'd3;
    wr_data[0 +: BL] = 64'h11;
    settle();
    advance();
    wr_data[0 +: BL] = 64'h22;
    rd_req = 4'b0001;
    rd_addr[0 +: AW] = 4'd3;
    settle();
    advance();
    wr_req = '0;
    settle();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 64'h11) begin
      n_err++;
      $display("FAIL collide_old got valid %b data %h exp 1 11", rd_valid, rd_data);
    end
    advance();
    rd_req = '0;
    settle();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 64'h22) begin
      n_err++;
      $display("FAIL collide_new got valid %b data %h exp 1 22", rd_valid, rd_data);
    end
    advance();
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    rd_req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_vec++;
      if (rd_gnt !== NR'(1 << k)) begin
        n_err++;
        $display("FAIL stream_gnt cyc %0d got %b exp %b", k, rd_gnt, NR'(1 << k));
      end
      advance();
    end
    rst_n = 1'b0;
    settle();
    n_vec++;
    if (rd_gnt !== 4'b0000 || mem_enb !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_gnt got gnt %b enb %b exp 0000 0", rd_gnt, mem_enb);
    end
    advance();
    rst_n = 1'b1;
    settle();
    n_vec++;
    if (rd_valid !== 1'b0 || rd_gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL midrst_resume got valid %b gnt %b exp 0 0001", rd_valid, rd_gnt);
    end
    advance();
    rd_req = '0;
    settle();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_id !== 2'd0) begin
      n_err++;
      $display("FAIL midrst_return got valid %b id %0d exp 1 0", rd_valid, rd_id);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      wr_req  = NW'($urandom);
      rd_req  = ($urandom_range(0, 3) == 0) ? NR'($urandom) : 4'b1111;
      wr_addr = NW*AW'($urandom);
      rd_addr = NR*AW'($urandom);
      wr_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      settle();
      n_vec++;
      if (wr_gnt !== e_wr_gnt || rd_gnt !== e_rd_gnt) begin
        n_err++;
        $display("FAIL rand_gnt cyc %0d got wr %b rd %b exp wr %b rd %b", c, wr_gnt, rd_gnt, e_wr_gnt, e_rd_gnt);
      end
      n_vec++;
      if (mem_ena !== (e_wi >= 0) || mem_wea !== (e_wi >= 0) || mem_enb !== (e_ri >= 0)) begin
        n_err++;
        $display("FAIL rand_en cyc %0d got ena %b wea %b enb %b exp %b %b %b",
                 c, mem_ena, mem_wea, mem_enb, e_wi >= 0, e_wi >= 0, e_ri >= 0);
      end
      n_vec++;
      if (mem_addra !== e_addra || mem_dina !== e_dina) begin
        n_err++;
        $display("FAIL rand_porta cyc %0d got addr %0d data %h exp addr %0d data %h", c, mem_addra, mem_dina, e_addra, e_dina);
      end
      if (e_ri >= 0) begin
        n_vec++;
        if (mem_addrb !== e_addrb) begin
          n_err++;
          $display("FAIL rand_addrb cyc %0d got %0d exp %0d", c, mem_addrb, e_addrb);
        end
      end
      n_vec++;
      if (rd_valid !== m_rd_valid || rd_id !== IW'(m_rd_id)) begin
        n_err++;
        $display("FAIL rand_rdtag cyc %0d got valid %b id %0d exp valid %b id %0d", c, rd_valid, rd_id, m_rd_valid, m_rd_id);
      end
      if (m_rd_valid && m_rd_known) begin
        n_vec++;
        if (rd_data !== m_rd_data) begin
          n_err++;
          $display("FAIL rand_rddata cyc %0d got %h exp %h", c, rd_data, m_rd_data);
        end
      end
      advance();
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    m_wr_ptr   = 0;
    m_rd_ptr   = 0;
    m_rd_valid = 0;
    m_rd_id    = 0;
    m_rd_known = 0;
    m_rd_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_pointer_skip();
    test_read_tag();
    test_collision();
    test_reset_mid_stream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one two_port_mem instance between NUM_WR write requesters on port A and NUM_RD read requesters on port B.
- Each port has an independent round-robin arbiter. A winner's request is forwarded to the memory in the same cycle it is granted.
- Read data returns one cycle after grant, tagged with the requester ID.
- Sits between the NN datapath engines (PE writers, weight/activation fetchers) and the buffer memory.

Parameters:
- BIT_LENGTH, 64, memory word width.
- DEPTH, 16, memory depth; AW = $clog2(DEPTH).
- NUM_WR, 4, number of write requesters (>=2).
- NUM_RD, 4, number of read requesters (>=2); IW = $clog2(NUM_RD).

Ports:
- clk  in  1  single clock; also drives memory clka/clkb.
- rst_n  in  1  synchronous, active-low reset.
- wr_req  in  NUM_WR  per-requester write request.
- wr_addr  in  NUM_WR*AW  packed write addresses; requester i at slice [i*AW +: AW].
- wr_data  in  NUM_WR*BIT_LENGTH  packed write data.
- wr_gnt  out  NUM_WR  one-hot write grant; the write is accepted this cycle.
- rd_req  in  NUM_RD  per-requester read request.
- rd_addr  in  NUM_RD*AW  packed read addresses.
- rd_gnt  out  NUM_RD  one-hot read grant; the read is accepted this cycle.
- rd_valid  out  1  read data valid.
- rd_id  out  IW  index of the requester owning rd_data.
- rd_data  out  BIT_LENGTH  read data (mem_doutb passthrough).
- mem_ena, mem_wea  out  1  memory port A enable and write enable.
- mem_addra  out  AW  memory port A address.
- mem_dina  out  BIT_LENGTH  memory port A write data.
- mem_enb  out  1  memory port B enable.
- mem_addrb  out  AW  memory port B address.
- mem_doutb  in  BIT_LENGTH  memory port B read data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - wr_ptr = 0, rd_ptr = 0, rd_valid = 0, rd_id = 0.
  - While rst_n is low, wr_gnt, rd_gnt, mem_ena, mem_wea and mem_enb are forced to 0 combinationally.
- Arbitration (identical on both ports):
  - Grant is combinational. The first asserted request at or after ptr, searching upward modulo N, wins.
  - At most one grant bit per port per cycle. Grant is 0 when no requests are asserted.
- Pointer update:
  - On a grant to index g, ptr <= (g+1) mod N at the next edge.
  - With no grant, ptr holds.
  - Bound: a continuously asserted requester is granted within N cycles.
- Handshake:
  - A request is consumed only in the cycle its grant is high.
  - A requester may drop its request at any time; there is no penalty and nothing is latched.
  - Addr/data need only be stable in the grant cycle.
- Write path: with grant g, mem_ena = mem_wea = 1, mem_addra = wr_addr[g], mem_dina = wr_data[g]. Otherwise mem_ena = mem_wea = 0 and addr/data = 0.
- Read path: with grant g, mem_enb = 1, mem_addrb = rd_addr[g].
- Read return:
  - At the next edge, rd_valid <= 1 and rd_id <= g. rd_data = mem_doutb in that cycle.
  - A read with no grant sets rd_valid <= 0; rd_id holds.
- Throughput: one write and one read per cycle sustained. Back-to-back reads give rd_valid high every cycle with successive IDs.
- Write/read collision: a same-cycle write and read to the same address returns the OLD word (memory read-first). There is no forwarding; requesters must order themselves.
- Reset mid-read: a grant in the cycle rst_n is low is suppressed, so no rd_valid follows. An in-flight rd_valid is cleared by reset.
- Out-of-range addresses (addr >= DEPTH when DEPTH is not a power of 2) are passed through unchecked.

Decomposition:
- Package mem_arb_pkg:
  - Width helper localparams: AW, IW, and WW = $clog2(NUM_WR).
  - An onehot-to-index function shared by both ports.
- Sub-module rr_arbiter #(N):
  - Ports: clk, rst_n, req[N], gnt[N], gnt_idx, gnt_valid.
  - Instantiated once for writes and once for reads.
  - The pointer lives inside rr_arbiter.

Test Plan:
- Reset: hold rst_n=0 with all requests high for 3 cycles -> all grants/enables 0, rd_valid 0. After release, the first write grant is wr_gnt=4'b0001.
- Round-robin fairness: all 4 write requests held high for 8 cycles -> wr_gnt sequence 0001, 0010, 0100, 1000, repeating. mem_addra/mem_dina track the granted slice.
- Pointer skip: wr_req=4'b1010 held, ptr=0 -> grants 0010, 1000, 0010, 1000.
- Read latency and tag: write 0xDEAD_BEEF to addr 5, then requester 2 reads addr 5 -> rd_gnt=0100, mem_addrb=5. Next cycle rd_valid=1, rd_id=2, rd_data=0xDEAD_BEEF.
- Collision: addr 3 holds 0x11; same cycle, write 0x22 to addr 3 and read addr 3 -> returned rd_data=0x11. A following read returns 0x22.
- Reset mid-stream: rd_req=4'b1111 streaming, then rst_n=0 for one cycle -> rd_valid=0 the cycle after. Arbitration resumes at rd_gnt=0001.
